// File: rtl/mem_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Width and depth constants match the 13-entry, 13-bit main memory.
package mem_pkg;

    localparam int DW    = 13;
    localparam int AW    = 13;
    localparam int DEPTH = 13;

    localparam logic P_FETCH = 1'b0;
    localparam logic P_LDST  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin grant: on a tie the port that did not win last time wins.
// Purely combinational; the last_grant history lives in the caller.
module rr_arb2
    import mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant,
    output logic       valid
);

    assign valid = |req;
    assign grant = (req == 2'b11) ? ~last_grant : (req[1] ? P_LDST : P_FETCH);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main memory between the fetch port (0) and load/store port (1).
// Sequences strobes until mem_done, range-checks, times out and acks each request.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int DW      = mem_pkg::DW,
    parameter int AW      = mem_pkg::AW,
    parameter int DEPTH   = mem_pkg::DEPTH,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          p0_req,
    input  logic [AW-1:0] p0_addr,
    output logic          p0_ack,
    output logic [DW-1:0] p0_rdata,
    output logic          p0_err,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_ack,
    output logic [DW-1:0] p1_rdata,
    output logic          p1_err,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_dataIn,
    output logic          mem_write,
    output logic          mem_read,
    input  logic [DW-1:0] mem_dataOut,
    input  logic          mem_done
);

    localparam logic [3:0]    TLAST      = 4'(TIMEOUT - 1);
    localparam logic [AW-1:0] ADDR_LIMIT = AW'(DEPTH);

    state_t        state, state_next;
    logic          last_grant;
    logic          gnt;
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic [3:0]    timer;

    logic          arb_grant, arb_valid;
    logic [AW-1:0] sel_addr;
    logic          sel_we, sel_ok, busy_end;

    logic          resp, resp_port, resp_err;
    logic [DW-1:0] resp_data;

    rr_arb2 u_arb (
        .req        ({p1_req, p0_req}),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .valid      (arb_valid)
    );

    assign sel_addr = (arb_grant == P_LDST) ? p1_addr : p0_addr;
    assign sel_we   = (arb_grant == P_LDST) & p1_we;
    assign sel_ok   = sel_addr < ADDR_LIMIT;
    // A done on the final timer cycle still counts as success.
    assign busy_end = mem_done || (timer == TLAST);

    assign mem_address = lat_addr;
    assign mem_dataIn  = lat_wdata;

    always_comb begin
        state_next = state;
        resp       = 1'b0;
        resp_port  = gnt;
        resp_err   = 1'b0;
        resp_data  = '0;
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    resp_port = arb_grant;
                    if (sel_ok) begin
                        state_next = BUSY;
                    end else begin
                        state_next = RESP;
                        resp       = 1'b1;
                        resp_err   = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (busy_end) begin
                    state_next = RESP;
                    resp       = 1'b1;
                    resp_err   = !mem_done;
                    resp_data  = (mem_done && !lat_we) ? mem_dataOut : '0;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            gnt        <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            timer      <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            p0_ack     <= 1'b0;
            p0_err     <= 1'b0;
            p0_rdata   <= '0;
            p1_ack     <= 1'b0;
            p1_err     <= 1'b0;
            p1_rdata   <= '0;
        end else begin
            state    <= state_next;
            p0_ack   <= resp && (resp_port == P_FETCH);
            p0_err   <= resp && (resp_port == P_FETCH) && resp_err;
            p0_rdata <= (resp && (resp_port == P_FETCH)) ? resp_data : '0;
            p1_ack   <= resp && (resp_port == P_LDST);
            p1_err   <= resp && (resp_port == P_LDST) && resp_err;
            p1_rdata <= (resp && (resp_port == P_LDST)) ? resp_data : '0;

            if (state == IDLE && arb_valid) begin
                last_grant <= arb_grant;
                gnt        <= arb_grant;
                lat_addr   <= sel_addr;
                lat_we     <= sel_we;
                lat_wdata  <= sel_we ? p1_wdata : '0;
                timer      <= '0;
                mem_read   <= sel_ok && !sel_we;
                mem_write  <= sel_ok && sel_we;
            end else if (state == BUSY) begin
                timer <= timer + 4'd1;
                if (busy_end) begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural memory and an ack scoreboard.
module tb_mem_arbiter;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        p0_req = 1'b0;
    logic [12:0] p0_addr = '0;
    logic        p0_ack, p0_err;
    logic [12:0] p0_rdata;
    logic        p1_req = 1'b0, p1_we = 1'b0;
    logic [12:0] p1_addr = '0, p1_wdata = '0;
    logic        p1_ack, p1_err;
    logic [12:0] p1_rdata;
    logic [12:0] mem_address, mem_dataIn, mem_dataOut;
    logic        mem_write, mem_read;
    logic        mem_done;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_address(mem_address), .mem_dataIn(mem_dataIn), .mem_write(mem_write),
        .mem_read(mem_read), .mem_dataOut(mem_dataOut), .mem_done(mem_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic [12:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          rd_cycles = 0;
    int          wr_cycles = 0;
    logic        done_en = 1'b1;
    logic [12:0] mem [13];

    initial begin
        for (int i = 0; i < 13; i++) mem[i] = 13'(i * 3 + 1);
        mem[5] = 13'h0A3;
        mem_done = 1'b0;
        mem_dataOut = '0;
    end

    // Memory completes on the negedge of the first strobe cycle.
    always @(negedge clk) begin
        if ((mem_read || mem_write) && done_en && !mem_done && mem_address < 13) begin
            mem_done <= 1'b1;
            if (mem_write) mem[mem_address] <= mem_dataIn;
            else           mem_dataOut <= mem[mem_address];
        end else begin
            mem_done <= 1'b0;
        end
    end

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic push(input int port, input logic [12:0] rdata, input logic err);
        exp_t e;
        e.port = port; e.rdata = rdata; e.err = err;
        sb.push_back(e);
    endtask

    // Monitor: pops one expectation per ack and tallies strobe cycles.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (mem_read) rd_cycles++;
            if (mem_write) wr_cycles++;
            if (mem_read || mem_write) chk("strobe_exclusive", int'(mem_read & mem_write), 0);
            if (p0_ack || p1_ack) begin
                chk("single_ack", int'(p0_ack & p1_ack), 0);
                if (sb.size() == 0) begin
                    chk("unexpected_ack", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("ack_port", p1_ack ? 1 : 0, e.port);
                    chk("ack_rdata", int'(p1_ack ? p1_rdata : p0_rdata), int'(e.rdata));
                    chk("ack_err", int'(p1_ack ? p1_err : p0_err), int'(e.err));
                end
            end
        end
    end

    task automatic do_req(input int port, input logic we, input logic [12:0] addr,
                          input logic [12:0] wdata, output int lat);
        bit got = 0;
        rd_cycles = 0;
        wr_cycles = 0;
        lat = 0;
        if (port == 0) begin
            p0_addr = addr; p0_req = 1'b1;
        end else begin
            p1_addr = addr; p1_we = we; p1_wdata = wdata; p1_req = 1'b1;
        end
        for (int i = 1; i <= 40 && !got; i++) begin
            @(posedge clk); #1;
            if ((port == 0 && p0_ack) || (port == 1 && p1_ack)) begin
                got = 1; lat = i;
            end
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        if (!got) chk("ack_wait", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        int order[3];
        int nacks;

        do_reset();
        chk("rst_p0_ack", int'(p0_ack), 0);
        chk("rst_p1_ack", int'(p1_ack), 0);
        chk("rst_err", int'({p0_err, p1_err}), 0);
        chk("rst_rdata", int'(p0_rdata | p1_rdata), 0);
        chk("rst_strobes", int'({mem_read, mem_write}), 0);
        chk("rst_mem_bus", int'(mem_address | mem_dataIn), 0);
        chk("rst_last_grant", int'(dut.last_grant), 1);
        chk("rst_timer", int'(dut.timer), 0);
        reset = 1'b1;
        @(posedge clk); #1;

        push(0, 13'h0A3, 1'b0);
        do_req(0, 1'b0, 13'd5, '0, lat);
        chk("read_latency", lat, 2);
        chk("read_strobe_cycles", rd_cycles, 1);

        push(1, 13'h0000, 1'b0);
        do_req(1, 1'b1, 13'd12, 13'h1FFF, lat);
        chk("write_strobe_cycles", wr_cycles, 1);
        chk("write_no_read", rd_cycles, 0);
        push(1, 13'h1FFF, 1'b0);
        do_req(1, 1'b0, 13'd12, '0, lat);
        chk("readback_latency", lat, 2);

        push(1, 13'h0000, 1'b1);
        do_req(1, 1'b0, 13'd13, '0, lat);
        chk("range_latency", lat, 1);
        chk("range_no_strobe", rd_cycles + wr_cycles, 0);

        // Both ports contend from reset: p0, p1, p0.
        do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        push(0, mem[3], 1'b0);
        push(1, mem[7], 1'b0);
        push(0, mem[3], 1'b0);
        p0_addr = 13'd3; p1_addr = 13'd7; p1_we = 1'b0;
        p0_req = 1'b1; p1_req = 1'b1;
        nacks = 0;
        for (int i = 0; i < 60 && nacks < 3; i++) begin
            @(posedge clk); #1;
            if (p0_ack || p1_ack) begin
                order[nacks] = p1_ack ? 1 : 0;
                nacks++;
                if (nacks == 3) begin
                    p0_req = 1'b0; p1_req = 1'b0;
                end else if (p1_ack) begin
                    p1_req = 1'b0; @(posedge clk); #1; p1_req = 1'b1;
                end else begin
                    p0_req = 1'b0; @(posedge clk); #1; p0_req = 1'b1;
                end
            end
        end
        chk("rr_acks", nacks, 3);
        chk("rr_order", order[0] * 4 + order[1] * 2 + order[2], 2);
        p0_req = 1'b0; p1_req = 1'b0;
        repeat (2) @(posedge clk); #1;

        done_en = 1'b0;
        push(0, 13'h0000, 1'b1);
        do_req(0, 1'b0, 13'd2, '0, lat);
        chk("timeout_latency", lat, 16);
        chk("timeout_strobe_cycles", rd_cycles, 15);
        done_en = 1'b1;
        push(0, 13'h0A3, 1'b0);
        do_req(0, 1'b0, 13'd5, '0, lat);
        chk("after_timeout_latency", lat, 2);

        done_en = 1'b0;
        p0_addr = 13'd4; p0_req = 1'b1;
        @(posedge clk); #1;
        chk("midrst_busy_strobe", int'(mem_read), 1);
        reset = 1'b0;
        p0_req = 1'b0;
        @(posedge clk); #1;
        chk("midrst_strobe_drop", int'(mem_read), 0);
        chk("midrst_no_ack", int'(p0_ack), 0);
        chk("midrst_state", int'(dut.state), int'(IDLE));
        reset = 1'b1;
        done_en = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("midrst_mem_intact", int'(mem[4]), 13);

        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
